ps2_mouse_ctrl: RTL
===================

# ps2_mouse_ctrl

Controller sitting above the PS/2 frame receiver and the PS/2 host transmitter. It runs the mouse power-up handshake: reset, self-test, ID, then enable data reporting. It validates every received 11-bit frame and assembles the three-byte stream-mode packets into button and motion outputs for the main loop. It owns the receiver enable, retries failed commands, and recovers packet alignment after errors or gaps.

## Interface
- `RESP_TIMEOUT`, default 25_000_000: `qzt_clk` cycles (1 s) allowed for any expected device response.
- `GAP_TIMEOUT`, default 50_000: cycles (2 ms) of silence that reset the packet byte index.
- `MAX_RETRIES`, default 3: command re-sends allowed before entering FAIL.
- `qzt_clk` in 1: 25 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `restart` in 1: one-cycle pulse that restarts initialisation from any state.
- `rx_data` in 11: frame from the receiver, first-received bit in [10]. Fields: [10] start, [9:2] D0..D7 (D0 at [9]), [1] parity, [0] stop.
- `rx_done` in 1: one-cycle pulse, `rx_data` valid.
- `rx_err` in 1: receiver timeout flag; treated as a bad frame when high at `rx_done`.
- `rx_enable` out 1: receiver enable.
- `tx_req` out 1: level request to the transmitter, held until `tx_done`.
- `tx_byte` out 8: command byte, stable while `tx_req` is high.
- `tx_done` in 1: one-cycle pulse, byte sent and line released.
- `pkt_valid` out 1: one-cycle pulse, packet outputs updated.
- `buttons` out 3: {middle, right, left}.
- `dx`, `dy` out 9: two's-complement motion.
- `ovf` out 2: {y_ovf, x_ovf}.
- `streaming` out 1: high in STREAM.
- `init_fail` out 1: high in FAIL.
- `err_count` out 8: saturating count of bad frames and dropped bytes.

## Operation
- Frame check: byte[i] = rx_data[9-i]. A frame is good when start = 0, stop = 1, `^rx_data[9:1]` = 1 (odd parity), and `rx_err` = 0.
- States: SEND_RST → WAIT_ACK1 → WAIT_BAT → WAIT_ID → SEND_EN → WAIT_ACK2 → STREAM. FAIL is a separate terminal state.
- SEND_x: raise `tx_req` with 0xFF or 0xF4 and drive `rx_enable` = 0. On `tx_done`, drop `tx_req`, set `rx_enable` = 1, start the response timer, and go to the next WAIT state.
- WAIT states expect these bytes:
  - ACK1 and ACK2: 0xFA.
  - BAT: 0xAA.
  - ID: 0x00.
- A good frame with the expected byte advances the state and reloads the timer.
- 0xFE, a bad frame, an unexpected byte, or timer expiry increments `retry`. If `retry` ≤ MAX_RETRIES, go back to the SEND state of the current command:
  - WAIT_ACK1, WAIT_BAT and WAIT_ID return to SEND_RST.
  - WAIT_ACK2 returns to SEND_EN.
- Otherwise go to FAIL. `retry` clears on entering SEND_EN from WAIT_ID.
- STREAM, byte index `idx` 0..2:
  - At idx 0, a good byte with bit3 = 1 is stored as b0 and idx becomes 1. A good byte with bit3 = 0 is dropped: `err_count`++, idx stays 0.
  - At idx 1 and 2, a good byte is stored and idx increments. At idx 2 the packet completes and idx wraps to 0.
  - A bad frame sets idx to 0 and increments `err_count`.
  - If no `rx_done` arrives for GAP_TIMEOUT cycles while idx ≠ 0, idx goes to 0 with no count.
- Packet mapping: `buttons` = b0[2:0], `dx` = {b0[4], b1}, `dy` = {b0[5], b2}, `ovf` = {b0[7], b0[6]}.
- FAIL: `rx_enable` = 0, waits for `restart`.
- `restart` in any state: go to SEND_RST, clear `retry` and idx. `err_count` is kept.
- `err_count` saturates at 255.

## Timing
- Reset values:
  - State SEND_RST, entered when `rst_n` deasserts; `tx_req` rises on the first clock edge after release.
  - `tx_req` = 0, `tx_byte` = 0xFF, `rx_enable` = 0.
  - `pkt_valid` = 0, `buttons` = 0, `dx` = 0, `dy` = 0, `ovf` = 0.
  - `streaming` = 0, `init_fail` = 0, `err_count` = 0.
- All outputs are registered.
- The `rx_done` that completes a packet, at edge N, produces `pkt_valid` and new data at N+1. Data holds until the next packet.
- `tx_done` at edge N: `tx_req` = 0 and `rx_enable` = 1 at N+1.
- `tx_req` never re-asserts in the cycle `tx_done` is seen.
- `rx_done` while in a SEND state is ignored.
- Simultaneous `restart` and `rx_done`: `restart` wins. Simultaneous timer expiry and a good expected frame: the frame wins.
- The response timer counts only in WAIT states. The gap timer counts only in STREAM with idx ≠ 0 and reloads on every `rx_done`.
- `rst_n` low mid-transfer drops `tx_req` immediately (asynchronous).

## Structure
- Package `ps2_pkg` holds:
  - Command constants CMD_RESET = 0xFF and CMD_ENABLE = 0xF4.
  - Response constants RSP_ACK = 0xFA, RSP_RESEND = 0xFE, RSP_BAT_OK = 0xAA, RSP_MOUSE_ID = 0x00.
  - The state encoding.
- One sub-module, `ps2_frame_check`, is purely combinational: `rx_data` and `rx_err` in, byte[7:0] and good out. The future keyboard controller will reuse it.

## Test plan
- Nominal init: device replies FA, AA, 00 to 0xFF, then FA to 0xF4 → `tx_byte` sequence FF then F4, `streaming` = 1, `retry` = 0.
- Resend: device replies FE to the first 0xFF, then a normal sequence → 0xFF sent twice, `streaming` = 1. Four consecutive FE replies → `init_fail` = 1 after 4 sends.
- Packet decode: frames 0x39, 0x10, 0xF0 → one `pkt_valid` with `buttons` = 001, `dx` = 0x110 (−240), `dy` = 0x1F0 (−16), `ovf` = 00.
- Resync: byte 0x10 (bit3 = 0) at idx 0, then 0x08, 0x05, 0x03 → `err_count` = 1, packet `dx` = 5, `dy` = 3.
- Parity error as the second byte → idx back to 0, `err_count` + 1, no `pkt_valid`. The following good three-byte packet decodes correctly.
- Gap and restart: two bytes, then 60_000 idle cycles, then three bytes → a single packet built from the last three. A `restart` pulse in STREAM → `tx_req` with 0xFF on the next cycle, `streaming` = 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 command/response constants and controller state encoding
package ps2_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_MOUSE_ID = 8'h00;

    typedef enum logic [2:0] {
        ST_SEND_RST  = 3'd0,
        ST_WAIT_ACK1 = 3'd1,
        ST_WAIT_BAT  = 3'd2,
        ST_WAIT_ID   = 3'd3,
        ST_SEND_EN   = 3'd4,
        ST_WAIT_ACK2 = 3'd5,
        ST_STREAM    = 3'd6,
        ST_FAIL      = 3'd7
    } ctrl_state_t;

    // States in which a command byte is being handed to the transmitter
    function automatic logic is_send_state(input ctrl_state_t s);
        return (s == ST_SEND_RST) || (s == ST_SEND_EN);
    endfunction

    // States in which a device response is pending and the response timer runs
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == ST_WAIT_ACK1) || (s == ST_WAIT_BAT) ||
               (s == ST_WAIT_ID)   || (s == ST_WAIT_ACK2);
    endfunction

    // Byte the device must return for the controller to leave a WAIT state
    function automatic logic [7:0] expected_rsp(input ctrl_state_t s);
        case (s)
            ST_WAIT_BAT: return RSP_BAT_OK;
            ST_WAIT_ID:  return RSP_MOUSE_ID;
            default:     return RSP_ACK;
        endcase
    endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// rtl/ps2_mouse_ctrl_if.sv - receiver/transmitter handshake and packet outputs of the mouse controller
interface ps2_mouse_ctrl_if;

    logic [10:0] rx_data;
    logic        rx_done;
    logic        rx_err;
    logic        rx_enable;
    logic        tx_req;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        pkt_valid;
    logic [2:0]  buttons;
    logic [8:0]  dx;
    logic [8:0]  dy;
    logic [1:0]  ovf;
    logic        streaming;
    logic        init_fail;
    logic [7:0]  err_count;

    modport master (
        input  rx_data, rx_done, rx_err, tx_done,
        output rx_enable, tx_req, tx_byte,
        output pkt_valid, buttons, dx, dy, ovf,
        output streaming, init_fail, err_count
    );

    modport slave (
        output rx_data, rx_done, rx_err, tx_done,
        input  rx_enable, tx_req, tx_byte,
        input  pkt_valid, buttons, dx, dy, ovf,
        input  streaming, init_fail, err_count
    );

endinterface

// File: rtl/ps2_frame_check.sv
// rtl/ps2_frame_check.sv - combinational 11-bit PS/2 frame validation and byte extraction
module ps2_frame_check (
    input  logic [10:0] rx_data,
    input  logic        rx_err,
    output logic [7:0]  rx_byte,
    output logic        good
);

    // Frame is sent LSB first, so data bit i sits at rx_data[9-i]
    always_comb begin
        rx_byte = '0;
        for (int i = 0; i < 8; i++) begin
            rx_byte[i] = rx_data[9-i];
        end
    end

    // Start low, stop high, odd parity over data+parity, and no receiver timeout
    assign good = ~rx_data[10] & rx_data[0] & (^rx_data[9:1]) & ~rx_err;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - PS/2 mouse init handshake, retry handling and stream packet assembly
module ps2_mouse_ctrl
    import ps2_pkg::*;
#(
    parameter int RESP_TIMEOUT = 25_000_000,
    parameter int GAP_TIMEOUT  = 50_000,
    parameter int MAX_RETRIES  = 3
) (
    input  logic             qzt_clk,
    input  logic             rst_n,
    input  logic             restart,
    ps2_mouse_ctrl_if.master bus
);

    localparam int RTW = $clog2(RESP_TIMEOUT + 1);
    localparam int GTW = $clog2(GAP_TIMEOUT + 1);
    localparam int RCW = $clog2(MAX_RETRIES + 2);

    localparam logic [RTW-1:0] RESP_LAST = RTW'(RESP_TIMEOUT - 1);
    localparam logic [GTW-1:0] GAP_LAST  = GTW'(GAP_TIMEOUT - 1);
    localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRIES);

    ctrl_state_t    state_q, state_d;
    logic [RCW-1:0] retry_q, retry_d;
    logic [RTW-1:0] resp_cnt_q;
    logic [GTW-1:0] gap_cnt_q;
    logic [1:0]     idx_q;
    logic [7:0]     b0_q, b1_q;

    logic           tx_req_q;
    logic [7:0]     tx_byte_q;
    logic           rx_enable_q;
    logic           pkt_valid_q;
    logic [2:0]     buttons_q;
    logic [8:0]     dx_q, dy_q;
    logic [1:0]     ovf_q;
    logic           streaming_q;
    logic           init_fail_q;
    logic [7:0]     err_count_q;

    logic [7:0]     rx_byte;
    logic           frame_good;
    logic           tx_ack;
    logic           in_wait;
    logic           in_stream;
    logic           resp_expired;
    logic           retry_step;
    logic           err_inc;

    ps2_frame_check u_frame_check (
        .rx_data (bus.rx_data),
        .rx_err  (bus.rx_err),
        .rx_byte (rx_byte),
        .good    (frame_good)
    );

    // A tx_done only counts while a request is actually outstanding
    assign tx_ack       = bus.tx_done & tx_req_q;
    assign in_wait      = is_wait_state(state_q);
    assign in_stream    = (state_q == ST_STREAM);
    assign resp_expired = in_wait & (resp_cnt_q == RESP_LAST);

    // Bad frames are counted wherever frames are listened to; bytes without
    // the sync bit are counted when dropped at the start of a packet
    assign err_inc = bus.rx_done & ~restart &
                     ((((in_wait | in_stream) & ~frame_good)) |
                      (in_stream & frame_good & (idx_q == 2'd0) & ~rx_byte[3]));

    // Next-state logic: handshake progress, retry accounting, restart override
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        retry_step = 1'b0;

        case (state_q)
            ST_SEND_RST: begin
                if (tx_ack) begin
                    state_d = ST_WAIT_ACK1;
                end
            end
            ST_SEND_EN: begin
                if (tx_ack) begin
                    state_d = ST_WAIT_ACK2;
                end
            end
            ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK2: begin
                // A frame arriving on the expiry cycle takes precedence over the timer
                if (bus.rx_done) begin
                    if (frame_good && (rx_byte == expected_rsp(state_q))) begin
                        case (state_q)
                            ST_WAIT_ACK1: state_d = ST_WAIT_BAT;
                            ST_WAIT_BAT:  state_d = ST_WAIT_ID;
                            ST_WAIT_ID: begin
                                state_d = ST_SEND_EN;
                                retry_d = '0;
                            end
                            default:      state_d = ST_STREAM;
                        endcase
                    end else begin
                        retry_step = 1'b1;
                    end
                end else if (resp_expired) begin
                    retry_step = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (retry_step) begin
            retry_d = retry_q + 1'b1;
            if (retry_q < RETRY_MAX) begin
                state_d = (state_q == ST_WAIT_ACK2) ? ST_SEND_EN : ST_SEND_RST;
            end else begin
                state_d = ST_FAIL;
            end
        end

        if (restart) begin
            state_d = ST_SEND_RST;
            retry_d = '0;
        end
    end

    // State and retry registers
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SEND_RST;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    // Response timer: runs only while parked in one WAIT state, restarts on any transition
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_cnt_q <= '0;
        end else if (in_wait && (state_d == state_q)) begin
            resp_cnt_q <= resp_cnt_q + 1'b1;
        end else begin
            resp_cnt_q <= '0;
        end
    end

    // Registered link-side outputs derived from the next state
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_req_q    <= 1'b0;
            tx_byte_q   <= CMD_RESET;
            rx_enable_q <= 1'b0;
            streaming_q <= 1'b0;
            init_fail_q <= 1'b0;
        end else begin
            // Never re-raise the request on the same edge that retires one
            tx_req_q    <= is_send_state(state_d) & ~tx_ack;
            if (is_send_state(state_d)) begin
                tx_byte_q <= (state_d == ST_SEND_EN) ? CMD_ENABLE : CMD_RESET;
            end
            rx_enable_q <= is_wait_state(state_d) | (state_d == ST_STREAM);
            streaming_q <= (state_d == ST_STREAM);
            init_fail_q <= (state_d == ST_FAIL);
        end
    end

    // Error counter, saturating so a noisy line cannot wrap it back to a small value
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    // Stream packet assembly with sync-bit alignment and inter-byte gap recovery
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            pkt_valid_q <= 1'b0;
            buttons_q   <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            ovf_q       <= '0;
        end else begin
            pkt_valid_q <= 1'b0;
            if (restart || !in_stream) begin
                idx_q     <= '0;
                gap_cnt_q <= '0;
            end else if (bus.rx_done) begin
                gap_cnt_q <= '0;
                if (!frame_good) begin
                    idx_q <= '0;
                end else begin
                    case (idx_q)
                        2'd0: begin
                            if (rx_byte[3]) begin
                                b0_q  <= rx_byte;
                                idx_q <= 2'd1;
                            end
                        end
                        2'd1: begin
                            b1_q  <= rx_byte;
                            idx_q <= 2'd2;
                        end
                        default: begin
                            buttons_q   <= b0_q[2:0];
                            dx_q        <= {b0_q[4], b1_q};
                            dy_q        <= {b0_q[5], rx_byte};
                            ovf_q       <= {b0_q[7], b0_q[6]};
                            pkt_valid_q <= 1'b1;
                            idx_q       <= 2'd0;
                        end
                    endcase
                end
            end else if (idx_q != 2'd0) begin
                if (gap_cnt_q == GAP_LAST) begin
                    idx_q     <= '0;
                    gap_cnt_q <= '0;
                end else begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                end
            end else begin
                gap_cnt_q <= '0;
            end
        end
    end

    assign bus.tx_req    = tx_req_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.rx_enable = rx_enable_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.buttons   = buttons_q;
    assign bus.dx        = dx_q;
    assign bus.dy        = dy_q;
    assign bus.ovf       = ovf_q;
    assign bus.streaming = streaming_q;
    assign bus.init_fail = init_fail_q;
    assign bus.err_count = err_count_q;

endmodule
